mc_sequencer: RTL

MC_SEQUENCER -- requirements
Module: mc_sequencer

---
 rtl/mc_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle control sequencer for a small RV32 core.
// Runs FETCH -> DECODE -> EXEC -> (MEM) -> WB for each instruction.
// It holds the instruction register, program counter and retired count.
// It stops in HALT on a SYSTEM opcode and in TRAP on any error.
//
// Ports:
//   clk, reset           rising-edge clock, async active-high reset
//   imem_req/addr        fetch request and address (addr always equals pc)
//   imem_ready/rdata     fetch completion and returned instruction
//   dmem_req/we          data access request; we=1 for stores
//   dmem_ready           data access completion
//   next_pc              next PC computed by the datapath
//   ir, pc               instruction register and program counter
//   rf_we                register-file write strobe (WB only)
//   state                current FSM encoding
//   halted, trap         terminal status flags
//   instret              retired-instruction counter
module mc_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] next_pc,
  output logic [31:0]     ir,
  output logic [XLEN-1:0] pc,
  output logic            rf_we,
  output logic [2:0]      state,
  output logic            halted,
  output logic            trap,
  output logic [31:0]     instret
);

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t         state_q;
  state_t         state_nx;
  logic [WCW-1:0] wait_cnt;
  logic [6:0]     opcode;
  logic           wait_expired;
  logic           pc_misaligned;
  logic           fetch_stall;
  logic           mem_stall;

  assign opcode        = ir[6:0];
  // The last allowed wait cycle: one more stall reaches TIMEOUT.
  assign wait_expired  = (wait_cnt == WAIT_LAST);
  assign pc_misaligned = (next_pc[1:0] != 2'b00);
  assign fetch_stall   = (state_q == ST_FETCH) && !imem_ready;
  assign mem_stall     = (state_q == ST_MEM) && !dmem_ready;

  assign imem_addr = pc;
  assign state     = state_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_nx;
    end
  end

  // Next-state logic. A ready input in the timeout cycle takes priority over the trap.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_RST:    state_nx = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready)        state_nx = ST_DECODE;
        else if (wait_expired) state_nx = ST_TRAP;
      end
      ST_DECODE: begin
        case (opcode)
          OP_REG, OP_IMM, OP_BRANCH, OP_JAL, OP_JALR,
          OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE: state_nx = ST_EXEC;
          OP_SYSTEM:                           state_nx = ST_HALT;
          default:                             state_nx = ST_TRAP;
        endcase
      end
      ST_EXEC: begin
        if (opcode == OP_LOAD || opcode == OP_STORE) state_nx = ST_MEM;
        else                                         state_nx = ST_WB;
      end
      ST_MEM: begin
        if (dmem_ready)        state_nx = ST_WB;
        else if (wait_expired) state_nx = ST_TRAP;
      end
      ST_WB: begin
        if (pc_misaligned) state_nx = ST_TRAP;
        else               state_nx = ST_FETCH;
      end
      ST_HALT:   state_nx = ST_HALT;
      ST_TRAP:   state_nx = ST_TRAP;
      default:   state_nx = ST_TRAP;
    endcase
  end

  // Architectural registers and the handshake wait counter.
  // The counter runs only while a request stalls, so it is zero on every FETCH/MEM entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      ir       <= NOP;
      instret  <= '0;
      wait_cnt <= '0;
    end else begin
      if (state_q == ST_FETCH && imem_ready) begin
        ir <= imem_rdata;
      end
      if (state_q == ST_WB && !pc_misaligned) begin
        pc      <= next_pc;
        instret <= instret + 32'd1;
      end
      if (fetch_stall || mem_stall) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Output decode. The only input that reaches an output is next_pc.
  // It suppresses the write strobe in an instruction that is about to trap on a misaligned target.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    halted   = 1'b0;
    trap     = 1'b0;
    case (state_q)
      ST_FETCH: imem_req = 1'b1;
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_STORE);
      end
      ST_WB: begin
        rf_we = (opcode != OP_STORE) && (opcode != OP_BRANCH) &&
                (ir[11:7] != 5'd0) && !pc_misaligned;
      end
      ST_HALT: halted = 1'b1;
      ST_TRAP: trap   = 1'b1;
      default: ;
    endcase
  end

endmodule
